nios_system_switch_pio_edge: RTL
================================

Name: nios_system_switch_pio_edge

Overview:
- Parametrised Avalon-MM input PIO slave; successor to the fixed 8-bit switch input port.
- Adds a synchroniser, per-bit debounce, edge capture with write-1-to-clear, and an interrupt mask driving a level IRQ to the Nios II.
- Sits between board switches/keys and the system interconnect.

Parameters:
DATA_WIDTH, 8, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable clocks required before the debounced bit changes; 0 = bypass
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  DATA_WIDTH  raw asynchronous inputs
readdata  out  32  registered read data
irq  out  1  level interrupt, active high

Behaviour:
- One clock (clk); reset_n is asynchronous, active-low. All flops clear on reset: sync chain, debounce counters, debounced value, irqmask, edgecapture, readdata = 0, so irq = 0.
- Register map (word addresses):
  - 0 data (RO, debounced value).
  - 1 reserved, reads 0.
  - 2 irqmask (RW, DATA_WIDTH bits).
  - 3 edgecapture (read; write 1 to clear a bit).
  - Upper bits read 0. Writes to 0/1 are ignored.
- Write occurs on a rising clk edge with chipselect=1 and write_n=0. No wait states.
- readdata is registered every cycle from the address mux, independent of chipselect: 1-cycle read latency. Reads have no side effects.
- Sync: in_port passes through SYNC_STAGES flops. The synced value s reflects in_port after SYNC_STAGES edges.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - When s==db, the counter is 0.
  - When s!=db, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, db <= s and the counter goes to 0.
  - Any glitch back to db before that resets the counter, so pulses shorter than DEBOUNCE_CYCLES clocks are discarded.
  - DEBOUNCE_CYCLES=0: db <= s every cycle.
- Total latency, in_port change to db: SYNC_STAGES+DEBOUNCE_CYCLES edges (bypass: SYNC_STAGES+1). readdata at address 0 shows it one edge later.
- Edge detect: an edge event on bit i fires on the same edge that db[i] changes, qualified by EDGE_TYPE (rising 0->1, falling 1->0, any).
- edgecapture[i] is sticky: set on an event, cleared only by a write with writedata[i]=1. If an event and a clear hit the same edge, set wins.
- irq = |(edgecapture & irqmask), combinational from registers. It asserts in the cycle after the capturing edge and drops after the clear or mask write edge.
- Reset mid-debounce abandons the count. After reset, db = 0; an input already high produces a rising event once it passes debounce.

Test Plan:
- Params 8/2/4/0. After reset, read addr0, 2, 3 -> readdata = 0x00000000; irq = 0.
- in_port 0x00->0xA5 held -> db updates at edge 6 after the change; addr0 reads 0x000000A5. edgecapture = 0xA5 (rising). With irqmask = 0, irq stays 0.
- Write irqmask = 0x01 with edgecapture = 0xA5 -> irq = 1 the cycle after the write. Write 0x01 to addr3 -> edgecapture = 0xA4, irq = 0.
- 3-cycle glitch on in_port[1] (0->1->0) -> db, edgecapture, and irq unchanged. 4-cycle pulse -> db[1] rises, then falls; edgecapture[1] = 1.
- Clear write to addr3 bit 2 on the same edge as a new rising event on bit 2 -> edgecapture[2] stays 1.
- EDGE_TYPE=2, DEBOUNCE_CYCLES=0: toggle in_port[7] -> db follows after 3 edges; both edges capture. Assert reset_n mid-count -> all registers 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/nios_system_switch_pio_edge.sv
// Avalon-MM input PIO: per-bit synchroniser and debounce, sticky edge capture
// with write-1-to-clear, and a masked level interrupt.

module nios_system_switch_pio_edge_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db,
    output logic db_nxt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   db_q, db_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        s      = sync_q[SYNC_STAGES-1];
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb db_d = s;
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

            // Counter only runs while s disagrees with db; any agreement restarts it.
            always_comb begin
                cnt_inc = cnt_q + 1'b1;
                cnt_d   = '0;
                db_d    = db_q;
                if (s != db_q) begin
                    if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                        db_d = s;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
        end
    end

    assign db     = db_q;
    assign db_nxt = db_d;

endmodule

module nios_system_switch_pio_edge #(
    parameter int DATA_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] db_q, db_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [DW-1:0] ec_q, ec_d;
    logic [DW-1:0] ev, clr;
    logic [31:0]   readdata_q, readdata_d;
    logic          wr_en;
    logic          unused_wdata;

    genvar i;
    generate
        for (i = 0; i < DW; i++) begin : g_lane
            nios_system_switch_pio_edge_lane #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_lane (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (in_port[i]),
                .db     (db_q[i]),
                .db_nxt (db_d[i])
            );
        end
    endgenerate

    // Events come from the debounced value's next state so capture lands on
    // the same edge that db changes.
    always_comb begin
        wr_en = chipselect & ~write_n;

        if (EDGE_TYPE == 1) begin
            ev = ~db_d & db_q;
        end else if (EDGE_TYPE == 2) begin
            ev = db_d ^ db_q;
        end else begin
            ev = db_d & ~db_q;
        end

        mask_d = mask_q;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[DW-1:0];
        end

        clr  = (wr_en && address == 2'd3) ? writedata[DW-1:0] : '0;
        ec_d = (ec_q & ~clr) | ev;

        case (address)
            2'd0:    readdata_d = 32'(db_q);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(ec_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            ec_q       <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            ec_q       <= ec_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata     = readdata_q;
    assign irq          = |(ec_q & mask_q);
    assign unused_wdata = ^writedata;

endmodule
